// File: rtl/f56_pkg.sv
// Shared definitions for the FALC56 command sequencer: engine register map,
// command-byte bit positions, status codes and the sequencer state encoding.
package f56_pkg;

    localparam logic [31:0] REG_STATUS = 32'h0000_0000;
    localparam logic [31:0] REG_RDATA  = 32'h0000_0004;
    localparam logic [31:0] REG_CMD    = 32'h0000_0008;

    localparam int CMD_RST = 7;
    localparam int CMD_CS  = 6;
    localparam int CMD_WR  = 3;
    localparam int CMD_ALE = 2;

    localparam logic [7:0] ST_IDLE = 8'h01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SNAP,
        S_ISSUE,
        S_POLL,
        S_FETCH
    } seq_state_e;

    typedef struct packed {
        logic [31:0] add;
        logic [31:0] data;
        logic        we;
    } wb_req_t;

    // Engine counters only ever move forward, so any change from the snapshot
    // means our command finished; inequality also covers the 8'hFF -> 8'h00 wrap.
    function automatic logic poll_done(input logic [7:0]  cmd,
                                       input logic [15:0] status,
                                       input logic [7:0]  wcnt,
                                       input logic [7:0]  rcnt);
        if (cmd[CMD_RST])
            return status[7:0] == ST_IDLE;
        else if (cmd[CMD_WR])
            return status[15:8] != wcnt;
        else
            return status[7:0] != rcnt;
    endfunction

endpackage

// File: rtl/f56_sync_fifo.sv
// Single-clock FIFO with register-array storage; head word is read straight
// from the array so the pop side always sees registered data.
module f56_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

    assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/f56_cmd_sequencer.sv
// Wishbone master that drains queued FALC56 commands into the register-bus
// engine, polls for completion and queues read-back bytes for the host.
module f56_cmd_sequencer
    import f56_pkg::*;
#(
    parameter int CMD_DEPTH   = 16,
    parameter int RES_DEPTH   = 16,
    parameter int TIMEOUT_CYC = 1023,
    parameter int GAP_CYC     = 2
) (
    input  logic        PHY_CLK33_I,
    input  logic        PHY_RST_I,
    input  logic        CMD_WR_I,
    input  logic [31:0] CMD_DATA_I,
    output logic        CMD_FULL_O,
    input  logic        RES_RD_I,
    output logic [7:0]  RES_DATA_O,
    output logic        RES_EMPTY_O,
    output logic        BUSY_O,
    output logic        ERR_O,
    input  logic        ERR_CLR_I,
    output logic [31:0] WB_ADD_O,
    output logic [31:0] WB_DATA_O,
    input  logic [31:0] WB_DATA_I,
    output logic        WB_STB_O,
    output logic        WB_WE_O,
    input  logic        WB_ACK_I,
    input  logic        WB_VALID_I
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int GAP_W = $clog2(GAP_CYC + 1);
    localparam logic [GAP_W-1:0] GAP_RLD = GAP_W'(GAP_CYC - 1);

    seq_state_e       state;
    seq_state_e       state_nxt;
    wb_req_t          req_nxt;
    wb_req_t          req_q;
    logic [31:0]      cmd_head;
    logic [31:0]      cmd_word;
    logic             cmd_empty;
    logic             cmd_pop;
    logic             res_full;
    logic             res_push;
    logic [7:0]       wcnt;
    logic [7:0]       rcnt;
    logic             stb;
    logic [GAP_W-1:0] gap_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             want_acc;
    logic             acc_done;
    logic             poll_ok;
    logic             tmo_hit;
    logic             err;
    logic             unused_wb_hi;

    assign unused_wb_hi = ^WB_DATA_I[31:16];

    f56_sync_fifo #(.WIDTH(32), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk   (PHY_CLK33_I),
        .rst   (PHY_RST_I),
        .push  (CMD_WR_I),
        .wdata (CMD_DATA_I),
        .pop   (cmd_pop),
        .rdata (cmd_head),
        .full  (CMD_FULL_O),
        .empty (cmd_empty)
    );

    f56_sync_fifo #(.WIDTH(8), .DEPTH(RES_DEPTH)) u_res_fifo (
        .clk   (PHY_CLK33_I),
        .rst   (PHY_RST_I),
        .push  (res_push),
        .wdata (WB_DATA_I[7:0]),
        .pop   (RES_RD_I),
        .rdata (RES_DATA_O),
        .full  (res_full),
        .empty (RES_EMPTY_O)
    );

    assign acc_done = stb && (req_q.we ? WB_ACK_I : WB_VALID_I);
    assign poll_ok  = poll_done(cmd_word[31:24], WB_DATA_I[15:0], wcnt, rcnt);
    // A completing poll in the expiry cycle still counts as success.
    assign tmo_hit  = (state == S_POLL) && (tmo_cnt == TMO_W'(TIMEOUT_CYC))
                      && !(acc_done && poll_ok);

    always_ff @(posedge PHY_CLK33_I or posedge PHY_RST_I) begin
        if (PHY_RST_I)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        want_acc  = 1'b0;
        req_nxt   = '0;
        cmd_pop   = 1'b0;
        res_push  = 1'b0;
        case (state)
            S_IDLE: begin
                if (!cmd_empty) begin
                    cmd_pop   = 1'b1;
                    state_nxt = S_SNAP;
                end
            end
            S_SNAP: begin
                want_acc = 1'b1;
                req_nxt  = '{add: REG_STATUS, data: 32'h0, we: 1'b0};
                if (acc_done)
                    state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                want_acc = 1'b1;
                req_nxt  = '{add: REG_CMD, data: cmd_word, we: 1'b1};
                if (acc_done)
                    state_nxt = S_POLL;
            end
            S_POLL: begin
                want_acc = !tmo_hit;
                req_nxt  = '{add: REG_STATUS, data: 32'h0, we: 1'b0};
                if (acc_done && poll_ok)
                    state_nxt = (cmd_word[24+CMD_RST] || cmd_word[24+CMD_WR]) ? S_IDLE : S_FETCH;
                else if (tmo_hit)
                    state_nxt = S_IDLE;
            end
            S_FETCH: begin
                // No access is started while the host has not made room.
                want_acc = !res_full;
                req_nxt  = '{add: REG_RDATA, data: 32'h0, we: 1'b0};
                if (acc_done) begin
                    res_push  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bus engine: one access at a time, then GAP_CYC cycles of STB low.
    always_ff @(posedge PHY_CLK33_I or posedge PHY_RST_I) begin
        if (PHY_RST_I) begin
            stb     <= 1'b0;
            gap_cnt <= '0;
            req_q   <= '0;
        end else if (stb) begin
            if (acc_done || tmo_hit) begin
                stb     <= 1'b0;
                gap_cnt <= GAP_RLD;
            end
        end else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
        end else if (want_acc) begin
            stb   <= 1'b1;
            req_q <= req_nxt;
        end
    end

    always_ff @(posedge PHY_CLK33_I or posedge PHY_RST_I) begin
        if (PHY_RST_I) begin
            cmd_word <= '0;
            wcnt     <= '0;
            rcnt     <= '0;
            tmo_cnt  <= '0;
            err      <= 1'b0;
        end else begin
            if (cmd_pop)
                cmd_word <= cmd_head;
            if (state == S_SNAP && acc_done) begin
                wcnt <= WB_DATA_I[15:8];
                rcnt <= WB_DATA_I[7:0];
            end
            if (state != S_POLL && state_nxt == S_POLL)
                tmo_cnt <= '0;
            else if (state == S_POLL)
                tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_hit)
                err <= 1'b1;
            else if (ERR_CLR_I)
                err <= 1'b0;
        end
    end

    assign WB_STB_O  = stb;
    assign WB_ADD_O  = req_q.add;
    assign WB_DATA_O = req_q.data;
    assign WB_WE_O   = req_q.we;
    assign ERR_O     = err;
    assign BUSY_O    = (state != S_IDLE) || !cmd_empty;

endmodule

// File: tb/tb_f56_cmd_sequencer.sv
// Bench for the FALC56 command sequencer: behavioural engine model on the WB
// side, scoreboard queues for issued command words and expected result bytes.
module tb_f56_cmd_sequencer;

    localparam int TMO = 1023;
    localparam int GAP = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        CMD_WR_I = 1'b0;
    logic [31:0] CMD_DATA_I = '0;
    logic        CMD_FULL_O;
    logic        RES_RD_I = 1'b0;
    logic [7:0]  RES_DATA_O;
    logic        RES_EMPTY_O;
    logic        BUSY_O;
    logic        ERR_O;
    logic        ERR_CLR_I = 1'b0;
    logic [31:0] WB_ADD_O;
    logic [31:0] WB_DATA_O;
    logic [31:0] WB_DATA_I = '0;
    logic        WB_STB_O;
    logic        WB_WE_O;
    logic        WB_ACK_I = 1'b0;
    logic        WB_VALID_I = 1'b0;

    always #15 clk = ~clk;

    f56_cmd_sequencer #(.CMD_DEPTH(16), .RES_DEPTH(16), .TIMEOUT_CYC(TMO), .GAP_CYC(GAP)) dut (
        .PHY_CLK33_I (clk),
        .PHY_RST_I   (rst),
        .CMD_WR_I    (CMD_WR_I),
        .CMD_DATA_I  (CMD_DATA_I),
        .CMD_FULL_O  (CMD_FULL_O),
        .RES_RD_I    (RES_RD_I),
        .RES_DATA_O  (RES_DATA_O),
        .RES_EMPTY_O (RES_EMPTY_O),
        .BUSY_O      (BUSY_O),
        .ERR_O       (ERR_O),
        .ERR_CLR_I   (ERR_CLR_I),
        .WB_ADD_O    (WB_ADD_O),
        .WB_DATA_O   (WB_DATA_O),
        .WB_DATA_I   (WB_DATA_I),
        .WB_STB_O    (WB_STB_O),
        .WB_WE_O     (WB_WE_O),
        .WB_ACK_I    (WB_ACK_I),
        .WB_VALID_I  (WB_VALID_I)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    logic [31:0] cmd_exp[$];
    logic [7:0]  res_exp[$];

    // Engine model state
    logic [7:0]  mem [256];
    logic [7:0]  eng_wcnt;
    logic [7:0]  eng_rcnt;
    logic [7:0]  eng_rdat = '0;
    logic [31:0] eng_cmd = '0;
    int          eng_timer = 0;
    int          eng_lat = 0;
    bit          eng_stall = 0;
    bit          eng_hold_wr = 0;
    int          rdata_reads = 0;
    int          cyc = 0;
    int          ack_cyc = 0;
    int          pop_budget = 0;

    task automatic eng_apply();
        if (eng_cmd[31])        eng_rcnt = 8'h01;
        else if (eng_cmd[27])   eng_wcnt = eng_wcnt + 8'd1;
        else begin
            eng_rcnt = eng_rcnt + 8'd1;
            eng_rdat = mem[eng_cmd[23:16]];
        end
    endtask

    // Engine: answers each strobe after 0-2 cycles, completes commands after 1-8 cycles.
    initial begin
        logic [31:0] r;
        forever begin
            @(negedge clk);
            cyc++;
            if (eng_timer > 0) begin
                eng_timer--;
                if (eng_timer == 0) eng_apply();
            end
            if (rst || !WB_STB_O) begin
                WB_ACK_I   = 1'b0;
                WB_VALID_I = 1'b0;
                eng_lat    = $urandom_range(0, 2);
            end else if (!WB_ACK_I && !WB_VALID_I) begin
                if (eng_lat > 0) eng_lat--;
                else if (WB_WE_O) begin
                    if (!eng_hold_wr) begin
                        WB_ACK_I = 1'b1;
                        check("wr_addr", WB_ADD_O, 32'h8);
                        check("cmd_expected", cmd_exp.size() != 0, 1);
                        if (cmd_exp.size() != 0) check("cmd_word", WB_DATA_O, cmd_exp.pop_front());
                        eng_cmd = WB_DATA_O;
                        ack_cyc = cyc;
                        if (!eng_stall) eng_timer = $urandom_range(1, 8);
                    end
                end else begin
                    r = $urandom;
                    WB_VALID_I = 1'b1;
                    if (WB_ADD_O == 32'h0) WB_DATA_I = {r[31:16], eng_wcnt, eng_rcnt};
                    else if (WB_ADD_O == 32'h4) begin
                        WB_DATA_I = {r[31:8], eng_rdat};
                        rdata_reads++;
                    end else check("rd_addr", WB_ADD_O, 32'h0);
                end
            end
        end
    end

    // Host pop side: compare every popped byte against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            RES_RD_I = 1'b0;
            if (!rst && !RES_EMPTY_O && pop_budget > 0 && $urandom_range(0, 3) != 0) begin
                check("res_expected", res_exp.size() != 0, 1);
                if (res_exp.size() != 0) check("res_data", RES_DATA_O, res_exp.pop_front());
                RES_RD_I = 1'b1;
                pop_budget--;
            end
        end
    end

    // Bus protocol: request stable while STB high, STB low >= GAP between accesses.
    initial begin
        logic [64:0] cap;
        bit prev = 0, seen_fall = 0, bad = 0;
        int low = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 0; seen_fall = 0;
            end else begin
                if (WB_STB_O && !prev) begin
                    if (seen_fall) check("stb_gap", low >= GAP, 1);
                    cap = {WB_ADD_O, WB_DATA_O, WB_WE_O};
                    bad = 0;
                end else if (WB_STB_O && cap != {WB_ADD_O, WB_DATA_O, WB_WE_O}) bad = 1;
                if (!WB_STB_O && prev) begin
                    check("req_stable", bad, 0);
                    seen_fall = 1;
                    low = 0;
                end
                if (!WB_STB_O) low++;
                prev = WB_STB_O;
            end
        end
    end

    task automatic push_cmd(input logic [31:0] w);
        int t = 0;
        while (CMD_FULL_O && t < 5000) begin @(negedge clk); t++; end
        if (t >= 5000) begin check("push_wait", 0, 1); return; end
        CMD_WR_I   = 1'b1;
        CMD_DATA_I = w;
        cmd_exp.push_back(w);
        if (!w[31] && !w[27]) res_exp.push_back(mem[w[23:16]]);
        @(negedge clk);
        CMD_WR_I = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int lim);
        int t = 0;
        while (BUSY_O && t < lim) begin @(negedge clk); t++; end
        check(name, t < lim, 1);
    endtask

    task automatic drain(input string name);
        int t = 0;
        pop_budget = 100000;
        while ((BUSY_O || res_exp.size() != 0 || !RES_EMPTY_O) && t < 20000) begin @(negedge clk); t++; end
        check(name, res_exp.size(), 0);
        check({name, "_empty"}, RES_EMPTY_O, 1);
        pop_budget = 0;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0]  w0;
        logic [31:0] r;
        int base, t, hi, dt;

        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h12] = 8'h5A;
        eng_wcnt = 8'($urandom);
        eng_rcnt = 8'h20;

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_stb", WB_STB_O, 0);
        check("rst_busy", BUSY_O, 0);
        check("rst_err", ERR_O, 0);
        check("rst_res_empty", RES_EMPTY_O, 1);
        check("rst_cmd_full", CMD_FULL_O, 0);
        check("rst_wb_add", WB_ADD_O, 0);
        check("rst_wb_we", WB_WE_O, 0);
        check("rst_res_data", RES_DATA_O, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single write: completes on wcnt change, no result.
        w0 = eng_wcnt;
        push_cmd(32'h0C12_00A5);
        wait_idle("wr_idle", 500);
        check("wr_wcnt", eng_wcnt, 8'(w0 + 8'd1));
        check("wr_no_result", RES_EMPTY_O, 1);
        check("wr_busy", BUSY_O, 0);

        // Single read returning 0x5A.
        push_cmd(32'h0412_0000);
        wait_idle("rd_idle", 500);
        check("rd_res_avail", RES_EMPTY_O, 0);
        check("rd_res_5a", RES_DATA_O, 8'h5A);
        drain("rd_drain");

        // rcnt wraps 0xFF -> 0x00.
        eng_rcnt = 8'hFF;
        push_cmd(32'h0433_0000);
        wait_idle("wrap_idle", 500);
        check("wrap_res_avail", RES_EMPTY_O, 0);
        check("wrap_rcnt", eng_rcnt, 8'h00);
        drain("wrap_drain");

        // 17 reads into a 16-deep result FIFO with no host pops.
        base = rdata_reads;
        for (int i = 0; i < 17; i++) push_cmd({8'h04, 8'(8'h40 + i), 16'h0});
        t = 0;
        while (rdata_reads - base < 16 && t < 5000) begin @(negedge clk); t++; end
        repeat (100) @(negedge clk);
        hi = 0;
        repeat (40) begin @(negedge clk); hi += int'(WB_STB_O); end
        check("fetch_stall_stb", hi, 0);
        check("fetch_stall_reads", rdata_reads - base, 16);
        check("fetch_stall_busy", BUSY_O, 1);
        for (int i = 0; i < 16; i++) push_cmd({8'h0C, 8'(i), 16'(i * 3)});
        check("cmd_full", CMD_FULL_O, 1);
        pop_budget = 1;
        t = 0;
        while (rdata_reads - base < 17 && t < 2000) begin @(negedge clk); t++; end
        check("fetch_17th", rdata_reads - base, 17);
        drain("fill_drain");

        // Timeout: engine never completes.
        eng_stall = 1;
        push_cmd(32'h0C55_1234);
        t = 0;
        while (!ERR_O && t < 3000) begin @(negedge clk); t++; end
        dt = cyc - ack_cyc;
        check("tmo_err", ERR_O, 1);
        check("tmo_cycles", (dt >= TMO) && (dt <= TMO + 4), 1);
        wait_idle("tmo_idle", 50);
        check("tmo_no_result", RES_EMPTY_O, 1);
        eng_stall = 0;
        push_cmd(32'h0477_0000);
        drain("tmo_next");
        check("err_sticky", ERR_O, 1);
        ERR_CLR_I = 1'b1;
        @(negedge clk);
        ERR_CLR_I = 1'b0;
        check("err_clr", ERR_O, 0);

        // Randomised mix of reset/write/read commands with random host pops.
        pop_budget = 100000;
        for (int i = 0; i < 40; i++) begin
            r = $urandom;
            case ($urandom_range(0, 5))
                0:       push_cmd({1'b1, r[30:0]});
                1, 2:    push_cmd({1'b0, r[30:28], 1'b1, r[26:0]});
                default: push_cmd({1'b0, r[30:28], 1'b0, r[26:0]});
            endcase
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 40)) @(negedge clk);
        end
        drain("rand_drain");
        check("rand_cmds_issued", cmd_exp.size(), 0);

        // Reset in the middle of a held write access.
        push_cmd(32'h0411_0000);
        wait_idle("prerst_rd", 500);
        eng_stall = 1;
        push_cmd(32'h0C66_0000);
        t = 0;
        while (!ERR_O && t < 3000) begin @(negedge clk); t++; end
        eng_stall = 0;
        eng_hold_wr = 1;
        for (int i = 0; i < 3; i++) push_cmd({8'h0C, 8'(8'h70 + i), 16'h0});
        t = 0;
        while (!(WB_STB_O && WB_WE_O) && t < 500) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        check("prerst_stb_held", WB_STB_O, 1);
        check("prerst_err", ERR_O, 1);
        check("prerst_res", RES_EMPTY_O, 0);
        rst = 1'b1;
        #1;
        check("mid_rst_stb", WB_STB_O, 0);
        check("mid_rst_busy", BUSY_O, 0);
        check("mid_rst_err", ERR_O, 0);
        check("mid_rst_cmd_full", CMD_FULL_O, 0);
        check("mid_rst_res_empty", RES_EMPTY_O, 1);
        cmd_exp.delete();
        res_exp.delete();
        eng_hold_wr = 0;
        eng_timer = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        push_cmd(32'h04AB_0000);
        drain("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
